serial_paralelo_phy_rx: RTL
===========================

# serial_paralelo_phy_rx

Receive-side PHY deserializer, the serial-to-parallel counterpart of the PHY transmit serializer. It takes a 1-bit MSB-first serial stream, sent one bit per clk, and recovers byte alignment by finding the 8'hBC comma idle symbol. It declares the link active after a run of aligned commas, then presents each non-comma byte on an 8-bit parallel bus with a valid flag. Comma bytes are idles and never appear as data.

## Interface
- BC_COUNT, default 4: consecutive aligned commas required to enter ACTIVE; legal range 1..15.
- clk  input  1  bit clock; one serial bit sampled per rising edge.
- reset  input  1  synchronous, active-low.
- inputS  input  1  serial data, MSB of each byte first.
- outputP  output  8  recovered data byte; held between updates.
- validOut  output  1  high while outputP carries a data (non-comma) byte.
- active  output  1  high while the FSM is in ACTIVE.
- bc_cnt_o  output  8  running count of received commas; present only with PHY_RX_BC_CNT_EN.

## Operation
- Shift register sr[7:0]: sr <= {sr[6:0], inputS} on every edge when reset is high.
- Candidate byte: cand = {sr[6:0], inputS}, which is the byte completed by the current bit.
- bit_cnt[2:0] counts bits of the current byte. byte_done is bit_cnt == 7. bit_cnt wraps 7 -> 0.
- FSM states, all with registered outputs:
  - SEARCH: compare cand on every edge. If cand == 8'hBC: bit_cnt <= 0, bc_run <= 1, then go to ACTIVE if BC_COUNT == 1, otherwise COUNT. Else stay in SEARCH.
  - COUNT: evaluate cand only on byte_done.
    - cand == BC: bc_run <= bc_run+1. If bc_run+1 == BC_COUNT, go to ACTIVE.
    - cand != BC: go to SEARCH, bc_run <= 0.
  - ACTIVE: evaluate cand only on byte_done.
    - cand != BC: outputP <= cand, validOut <= 1.
    - cand == BC: validOut <= 0, outputP holds.
    - No exit except reset.
- bc_run is 4-bit.
- Reset (reset == 0 at an edge) applies regardless of state:
  - state <= SEARCH; sr, bit_cnt, bc_run <= 0.
  - outputP <= 8'h00, validOut <= 0, active <= 0, bc_cnt_o <= 0.
- Reset asserted mid-byte or mid-ACTIVE discards the partial byte and all alignment. After reset releases, alignment must be reacquired from SEARCH.
- Data bytes equal to 8'hBC are indistinguishable from idles by protocol definition. They are dropped.

## Timing
- Serial rate is 1 bit/clk. Parallel updates occur once per 8 clks, at byte_done edges only.
- Latency: the last bit (LSB) of a byte is sampled at edge N. outputP, validOut, and the state change are visible after edge N. This is zero added cycles beyond the bit period.
- outputP and validOut are stable for 8 clks between byte_done edges.
- active rises after the edge that accepts the BC_COUNT-th aligned comma. The first data byte can follow immediately.
- Minimum acquisition, with the stream aligned: 8*BC_COUNT clks after the first comma's MSB.

## Configuration
- PHY_RX_BC_CNT_EN defined:
  - bc_cnt_o port exists.
  - Increments on every comma detection: in SEARCH on detection, in COUNT/ACTIVE on byte_done with cand == BC.
  - Saturates at 8'hFF.
  - Reset to 0.
- PHY_RX_BC_CNT_EN undefined: no port and no counter logic. Behaviour is otherwise identical.

## Structure
- Shared package phy_pkg holds:
  - localparam COMMA_BC = 8'hBC, shared with the TX serializer.
  - State enum {SEARCH, COUNT, ACTIVE} as a 2-bit typedef.
- One sub-module, phy_rx_comma_detect: the shift register plus cand == COMMA_BC compare. It outputs cand[7:0] and is_bc.
- FSM, counters, and output registers stay in the top module.

## Test plan
- Reset hold: reset = 0 for 5 clks with random inputS -> outputP = 0, validOut = 0, active = 0, and the state stays SEARCH.
- Acquisition, BC_COUNT = 4: 3 random bits, then 4× 8'hBC -> active = 1 after the edge of the 4th comma's LSB. validOut stays 0.
- Data path: after acquisition, send 8'hA5, 8'h3C, 8'hBC -> outputP = A5 with validOut = 1 for 8 clks, then 3C with validOut = 1, then validOut = 0 with outputP holding 3C.
- Broken count: 2× BC, then 8'h00, then 4× BC -> the FSM returns to SEARCH after the 8'h00. active rises only after the later 4 commas.
- Reset mid-ACTIVE: assert reset for 1 clk in the middle of byte 8'h5A -> all outputs 0 and SEARCH. The partial byte never appears. Reacquisition needs 4 fresh commas.
- PHY_RX_BC_CNT_EN: 300 consecutive commas -> bc_cnt_o = 8'hFF and holds there. The counter is absent when the macro is undefined.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared PHY definitions used by both the TX serializer and the RX deserializer.
//   COMMA_BC        : idle/alignment comma symbol
//   phy_rx_state_e  : receive alignment FSM states
package phy_pkg;

  localparam logic [7:0] COMMA_BC = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    COUNT  = 2'd1,
    ACTIVE = 2'd2
  } phy_rx_state_e;

endpackage

// File: rtl/serial_paralelo_phy_rx_if.sv
// Bus bundle between a serial source/parallel sink and the RX deserializer.
// Optional macro: PHY_RX_BC_CNT_EN adds the bc_cnt_o comma counter signal.
//   inputS   : serial bit stream, MSB of each byte first
//   outputP  : recovered data byte
//   validOut : outputP holds a data (non-comma) byte
//   active   : link aligned and delivering data
//   bc_cnt_o : saturating count of received commas (optional)
// Modports: master = stream source / byte consumer, slave = deserializer.
interface serial_paralelo_phy_rx_if;
  logic       inputS;
  logic [7:0] outputP;
  logic       validOut;
  logic       active;
`ifdef PHY_RX_BC_CNT_EN
  logic [7:0] bc_cnt_o;
`endif

  modport master (
    output inputS,
    input  outputP,
    input  validOut,
`ifdef PHY_RX_BC_CNT_EN
    input  bc_cnt_o,
`endif
    input  active
  );

  modport slave (
    input  inputS,
    output outputP,
    output validOut,
`ifdef PHY_RX_BC_CNT_EN
    output bc_cnt_o,
`endif
    output active
  );
endinterface

// File: rtl/phy_rx_comma_detect.sv
// Serial shift register and comma compare for the RX deserializer.
//   clk     : bit clock
//   reset   : synchronous, active-low
//   i_bit   : incoming serial bit
//   o_cand  : byte completed by the current bit, {history, i_bit}
//   o_is_bc : o_cand equals the comma symbol
module phy_rx_comma_detect
  import phy_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_bit,
  output logic [7:0] o_cand,
  output logic       o_is_bc
);

  // Only the seven most recent bits are kept: the oldest bit of an 8-bit
  // history would fall out of every candidate window and is never looked at.
  logic [6:0] r_sr;

  always_ff @(posedge clk) begin
    if (!reset) r_sr <= '0;
    else        r_sr <= o_cand[6:0];
  end

  assign o_cand  = {r_sr, i_bit};
  assign o_is_bc = (o_cand == COMMA_BC);

endmodule

// File: rtl/serial_paralelo_phy_rx.sv
// Receive-side PHY deserializer. Finds byte alignment on the 8'hBC comma,
// declares the link ACTIVE after BC_COUNT aligned commas, then presents each
// non-comma byte on outputP with validOut. Commas are idles, never data.
// Optional macro: PHY_RX_BC_CNT_EN adds the saturating bc_cnt_o comma counter.
// Ports:
//   clk   : bit clock, one serial bit per rising edge
//   reset : synchronous, active-low; clears all state and outputs
//   bus   : serial_paralelo_phy_rx_if.slave (inputS, outputP, validOut,
//           active, bc_cnt_o when enabled)
// Parameter: BC_COUNT (1..15) aligned commas needed to enter ACTIVE.
module serial_paralelo_phy_rx
  import phy_pkg::*;
#(
  parameter int BC_COUNT = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  serial_paralelo_phy_rx_if.slave       bus
);

  localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

  logic [7:0]    w_cand;
  logic          w_is_bc;
  logic          w_byte_done;

  phy_rx_state_e r_state, w_state_nxt;
  logic [2:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [3:0]    r_bc_run, w_bc_run_nxt;
  logic [7:0]    r_out, w_out_nxt;
  logic          r_vld, w_vld_nxt;
  logic          r_act, w_act_nxt;

  phy_rx_comma_detect u_comma_detect (
    .clk     (clk),
    .reset   (reset),
    .i_bit   (bus.inputS),
    .o_cand  (w_cand),
    .o_is_bc (w_is_bc)
  );

  assign w_byte_done = (r_bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= SEARCH;
      r_bit_cnt <= '0;
      r_bc_run  <= '0;
      r_out     <= 8'h00;
      r_vld     <= 1'b0;
      r_act     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bc_run  <= w_bc_run_nxt;
      r_out     <= w_out_nxt;
      r_vld     <= w_vld_nxt;
      r_act     <= w_act_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
    w_bc_run_nxt  = r_bc_run;
    w_out_nxt     = r_out;
    w_vld_nxt     = r_vld;

    unique case (r_state)
      SEARCH: begin
        // Unaligned: any bit position may end a comma. A hit fixes the byte
        // boundary, so the next bit is bit 0 of a new byte.
        if (w_is_bc) begin
          w_bit_cnt_nxt = 3'd0;
          w_bc_run_nxt  = 4'd1;
          w_state_nxt   = (BC_TARGET == 4'd1) ? ACTIVE : COUNT;
        end
      end
      COUNT: begin
        if (w_byte_done) begin
          if (w_is_bc) begin
            w_bc_run_nxt = r_bc_run + 4'd1;
            if (r_bc_run + 4'd1 == BC_TARGET) w_state_nxt = ACTIVE;
          end else begin
            w_bc_run_nxt = 4'd0;
            w_state_nxt  = SEARCH;
          end
        end
      end
      ACTIVE: begin
        if (w_byte_done) begin
          if (w_is_bc) begin
            w_vld_nxt = 1'b0;
          end else begin
            w_out_nxt = w_cand;
            w_vld_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = SEARCH;
    endcase

    w_act_nxt = (w_state_nxt == ACTIVE);
  end

  assign bus.outputP  = r_out;
  assign bus.validOut = r_vld;
  assign bus.active   = r_act;

`ifdef PHY_RX_BC_CNT_EN
  logic [7:0] r_bc_cnt;
  logic       w_bc_hit;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Every comma counts: any bit position while searching, byte boundaries
  // once aligned.
  assign w_bc_hit = (r_state == SEARCH) ? w_is_bc : (w_byte_done && w_is_bc);

  always_ff @(posedge clk) begin
    if (!reset)        r_bc_cnt <= 8'h00;
    else if (w_bc_hit) r_bc_cnt <= sat_inc8(r_bc_cnt);
  end

  assign bus.bc_cnt_o = r_bc_cnt;
`endif

endmodule
